mem_io_responder: RTL and testbench

Memory-side responder for the CPU's byte-wide memory bus: the block the CPU's `mem_a`/`mem_dout`/`mem_wr`/`mem_din` initiator talks to. It provides the 128 KB byte RAM, the memory-mapped I/O page at 0x30000, a UART transmit FIFO that drives `io_buffer_full`, a receive-byte port, and a free-running cycle counter. It is used as the simulation and FPGA counterpart of `cpu`, and sits between `cpu` and the UART.

---
 rtl/mem_io_responder.sv | 134 +++++++++++++
 tb/tb_mem_io_responder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// Memory-side responder for the CPU byte bus: 128 KB RAM, I/O page at 0x30000, UART TX FIFO, RX port.
// Define IO_CYCLE_COUNTER_EN to build the free-running cycle counter readable at 0x30004-0x30007.
module mem_io_responder #(
   parameter int ADDR_WIDTH = 17,
   parameter int TX_DEPTH   = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        program_end,
   output logic        tx_overflow
);

   localparam int PTR_W     = $clog2(TX_DEPTH);
   localparam int RAM_WORDS = 1 << ADDR_WIDTH;
   localparam logic [PTR_W:0] DEPTH_C  = (PTR_W+1)'(TX_DEPTH);
   localparam logic [PTR_W:0] ALMOST_C = (PTR_W+1)'(TX_DEPTH - 2);

   logic                  io;
   logic [15:0]           io_off;
   logic [ADDR_WIDTH-1:0] ram_idx;
   logic [7:0]            ram [RAM_WORDS];
   logic [7:0]            rd_byte;
   logic                  unused_addr_bits;

   assign io               = (mem_a[17:16] == 2'b11);
   assign io_off           = mem_a[15:0];
   assign ram_idx          = mem_a[ADDR_WIDTH-1:0];
   assign unused_addr_bits = ^mem_a[31:18];

   always_ff @(posedge clk_in) begin
      if (!io && mem_wr)
         ram[ram_idx] <= mem_din;
   end

`ifdef IO_CYCLE_COUNTER_EN
   logic [31:0] cycle_cnt;
   logic [31:0] snap;

   // snap freezes the whole counter on the byte-0 read so bytes 1-3 stay coherent.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         cycle_cnt <= 32'h0;
         snap      <= 32'h0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'h1;
         if (io && !mem_wr && io_off == 16'h0004)
            snap <= cycle_cnt;
      end
   end
`endif

   always_comb begin
      rd_byte  = 8'h00;
      rx_ready = 1'b0;
      if (!io) begin
         rd_byte = ram[ram_idx];
      end else if (!mem_wr) begin
         case (io_off)
            16'h0000: begin
               rx_ready = rx_valid;
               rd_byte  = rx_valid ? rx_data : 8'h00;
            end
`ifdef IO_CYCLE_COUNTER_EN
            16'h0004: rd_byte = cycle_cnt[7:0];
            16'h0005: rd_byte = snap[15:8];
            16'h0006: rd_byte = snap[23:16];
            16'h0007: rd_byte = snap[31:24];
`endif
            default:  rd_byte = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)
         mem_dout <= 8'h00;
      else if (!mem_wr)
         mem_dout <= rd_byte;
   end

   logic [7:0]   tx_mem [TX_DEPTH];
   logic [PTR_W:0] wr_ptr, rd_ptr, count, count_nxt;
   logic         full, push_req, push_ok, pop, halt_wr;
   logic [7:0]   push_data;

   assign halt_wr   = io && mem_wr && (io_off == 16'h0004);
   assign push_req  = halt_wr || (io && mem_wr && io_off == 16'h0000 && mem_din != 8'h00);
   assign push_data = halt_wr ? 8'h00 : mem_din;
   assign count     = wr_ptr - rd_ptr;
   assign full      = (count == DEPTH_C);
   assign tx_valid  = (wr_ptr != rd_ptr);
   assign tx_data   = tx_valid ? tx_mem[rd_ptr[PTR_W-1:0]] : 8'h00;
   assign pop       = tx_valid && tx_ready;
   // When full, a simultaneous pop frees the slot the push lands in.
   assign push_ok   = push_req && (!full || pop);
   assign count_nxt = count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);

   always_ff @(posedge clk_in) begin
      if (push_ok)
         tx_mem[wr_ptr[PTR_W-1:0]] <= push_data;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         io_buffer_full <= 1'b0;
         tx_overflow    <= 1'b0;
         program_end    <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         io_buffer_full <= (count_nxt >= ALMOST_C);
         if (push_req && !push_ok)
            tx_overflow <= 1'b1;
         if (halt_wr)
            program_end <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder with read/TX scoreboard queues.
module tb_mem_io_responder;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic [31:0] mem_a = 32'h0;
   logic        mem_wr = 1'b0;
   logic [7:0]  mem_din = 8'h00;
   logic [7:0]  mem_dout;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        program_end;
   logic        tx_overflow;

   mem_io_responder #(.ADDR_WIDTH(17), .TX_DEPTH(8)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_wr(mem_wr),
      .mem_din(mem_din), .mem_dout(mem_dout), .io_buffer_full(io_buffer_full),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .program_end(program_end), .tx_overflow(tx_overflow)
   );

   always #5 clk_in = ~clk_in;

   int n_assert = 0;
   int n_fail   = 0;
   logic [7:0] rd_q[$];
   logic [7:0] tx_q[$];
   logic [31:0] cnt_exp;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one bus cycle at a negedge, return at the next negedge.
   task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
      mem_a = a; mem_wr = wr; mem_din = d;
      @(negedge clk_in);
   endtask

   task automatic rd(input logic [31:0] a, input logic [7:0] exp);
      logic [7:0] e;
      rd_q.push_back(exp);
      bus(a, 1'b0, 8'h00);
      e = rd_q.pop_front();
      chk($sformatf("rd_%05h", a), {24'h0, mem_dout}, {24'h0, e});
   endtask

   task automatic tx_push(input logic [7:0] d);
      if (d != 8'h00 && tx_q.size() < 8)
         tx_q.push_back(d);
      bus(32'h30000, 1'b1, d);
   endtask

   task automatic drain(input int budget);
      logic [7:0] e;
      tx_ready = 1'b1; mem_a = 32'h0; mem_wr = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (tx_q.size() == 0) break;
         if (tx_valid) begin
            e = tx_q.pop_front();
            chk("tx_data", {24'h0, tx_data}, {24'h0, e});
         end
         @(negedge clk_in);
      end
      chk("drain_done", tx_q.size(), 0);
      chk("drain_tx_valid", {31'h0, tx_valid}, 0);
      tx_ready = 1'b0;
   endtask

   initial begin
`ifdef IO_CYCLE_COUNTER_EN
      cnt_exp = 32'd1000;
`else
      cnt_exp = 32'd0;
`endif
      repeat (3) @(negedge clk_in);
      chk("rst_mem_dout", {24'h0, mem_dout}, 0);
      chk("rst_tx_valid", {31'h0, tx_valid}, 0);
      chk("rst_tx_data", {24'h0, tx_data}, 0);
      chk("rst_ibf", {31'h0, io_buffer_full}, 0);
      chk("rst_prog_end", {31'h0, program_end}, 0);
      chk("rst_overflow", {31'h0, tx_overflow}, 0);
      rst_in = 1'b1;

      // Counter snapshot 1000 edges after release
      repeat (1000) @(posedge clk_in);
      @(negedge clk_in);
      rd(32'h30004, cnt_exp[7:0]);
      rd(32'h30005, cnt_exp[15:8]);
      rd(32'h30006, cnt_exp[23:16]);
      rd(32'h30007, cnt_exp[31:24]);

      // RAM write / read / alias / hold on write
      bus(32'h00100, 1'b1, 8'hA5);
      rd(32'h00100, 8'hA5);
      rd(32'h20100, 8'hA5);
      bus(32'h00200, 1'b1, 8'h11);
      chk("hold_on_write", {24'h0, mem_dout}, 32'hA5);
      rd(32'h00200, 8'h11);
      rd(32'h30008, 8'h00);

      // RX port
      rx_valid = 1'b1; rx_data = 8'h37;
      mem_a = 32'h00100; mem_wr = 1'b0;
      #1 chk("rx_ready_ram", {31'h0, rx_ready}, 0);
      mem_a = 32'h30000;
      #1 chk("rx_ready_hi", {31'h0, rx_ready}, 1);
      @(negedge clk_in);
      chk("rx_data", {24'h0, mem_dout}, 32'h37);
      rx_valid = 1'b0;
      #1 chk("rx_ready_lo", {31'h0, rx_ready}, 0);
      @(negedge clk_in);
      chk("rx_empty", {24'h0, mem_dout}, 0);

      // Zero filter and drain
      tx_push(8'h41);
      tx_push(8'h00);
      tx_push(8'h42);
      chk("tx_head", {24'h0, tx_data}, 32'h41);
      chk("tx_ibf_2", {31'h0, io_buffer_full}, 0);
      drain(10);

      // Fill, almost-full, overflow, push with pop when full
      for (int i = 1; i <= 9; i++) begin
         tx_push(8'h60 + 8'(i));
         if (i == 5) chk("ibf_5", {31'h0, io_buffer_full}, 0);
         if (i == 6) chk("ibf_6", {31'h0, io_buffer_full}, 1);
         if (i == 8) chk("ovf_8", {31'h0, tx_overflow}, 0);
         if (i == 9) chk("ovf_9", {31'h0, tx_overflow}, 1);
      end
      tx_ready = 1'b1;
      chk("full_head", {24'h0, tx_data}, {24'h0, tx_q[0]});
      void'(tx_q.pop_front());
      tx_q.push_back(8'h70);
      bus(32'h30000, 1'b1, 8'h70);
      chk("ibf_full_pp", {31'h0, io_buffer_full}, 1);
      drain(40);
      chk("ibf_drained", {31'h0, io_buffer_full}, 0);

      // Halt write, then reset mid-drain
      tx_q.push_back(8'h00);
      bus(32'h30004, 1'b1, 8'h5A);
      chk("prog_end", {31'h0, program_end}, 1);
      chk("halt_valid", {31'h0, tx_valid}, 1);
      chk("halt_byte", {24'h0, tx_data}, 0);
      tx_push(8'h41);
      bus(32'h00000, 1'b0, 8'h00);
      chk("prog_end_sticky", {31'h0, program_end}, 1);
      tx_ready = 1'b1;
      chk("drain_halt", {24'h0, tx_data}, {24'h0, tx_q[0]});
      void'(tx_q.pop_front());
      bus(32'h00100, 1'b0, 8'h00);
      chk("pre_rst_dout", {24'h0, mem_dout}, 32'hA5);
      chk("pre_rst_tx", {24'h0, tx_data}, 32'h41);
      #3 rst_in = 1'b0;
      #1;
      chk("arst_mem_dout", {24'h0, mem_dout}, 0);
      chk("arst_tx_valid", {31'h0, tx_valid}, 0);
      chk("arst_tx_data", {24'h0, tx_data}, 0);
      chk("arst_ibf", {31'h0, io_buffer_full}, 0);
      chk("arst_prog_end", {31'h0, program_end}, 0);
      chk("arst_overflow", {31'h0, tx_overflow}, 0);
      tx_q.delete();
      tx_ready = 1'b0;
      @(negedge clk_in);
      rst_in = 1'b1;
      rd(32'h30004, 8'h00);
      rd(32'h30005, 8'h00);
      chk("post_rst_tx_valid", {31'h0, tx_valid}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
